// File: rtl/conv_ibuf_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_ibuf_ctrl_if : pixel-in / CIM-beat-out handshake bundle      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface conv_ibuf_ctrl_if #(
  parameter int INPUT_CHANNELS = 2,
  parameter int COUNT_WIDTH    = 3,
  parameter int ADDR_WIDTH     = 1
);
  logic                      i_pix_valid;
  logic                      o_pix_ready;
  logic [INPUT_CHANNELS-1:0] o_write_enable;
  logic [COUNT_WIDTH-1:0]    o_count;
  logic [ADDR_WIDTH-1:0]     o_ibuf_addr;
  logic                      o_cim_valid;
  logic                      i_cim_ready;
  logic                      o_win_last;
  logic                      o_img_done;

  // master: the sequencer; slave: the surrounding pixel source / CIM side
  modport master (
    input  i_pix_valid, i_cim_ready,
    output o_pix_ready, o_write_enable, o_count, o_ibuf_addr,
           o_cim_valid, o_win_last, o_img_done
  );
  modport slave (
    output i_pix_valid, i_cim_ready,
    input  o_pix_ready, o_write_enable, o_count, o_ibuf_addr,
           o_cim_valid, o_win_last, o_img_done
  );
endinterface
`default_nettype wire

// File: rtl/conv_ibuf_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_ibuf_ctrl : conv input-buffer fill / window read sequencer  |
// | Option macro: CONV_IBUF_STRIDE2_EN (stride-2 window emission)     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module conv_ibuf_ctrl #(
  parameter int DATA_SIZE      = 8,
  parameter int IMG_DIM        = 28,
  parameter int KERNEL_DIM     = 3,
  parameter int INPUT_CHANNELS = 2,
  parameter int NUM_ADDR       = 2,
  parameter int COUNT_WIDTH    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1,
  parameter int ADDR_WIDTH     = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input  logic              clk,
  input  logic              rst,
  conv_ibuf_ctrl_if.master  bus
);

  localparam int POS_W = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam logic [POS_W-1:0]       POS_MAX  = POS_W'(IMG_DIM - 1);
  localparam logic [POS_W-1:0]       K_EDGE   = POS_W'(KERNEL_DIM - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = COUNT_WIDTH'(DATA_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_MAX = ADDR_WIDTH'(NUM_ADDR - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [POS_W-1:0]       row;
  logic [POS_W-1:0]       col;
  logic [COUNT_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   last_pix;

  logic accept;
  logic in_window;
  logic is_last_pix;
  logic beat;
  logic beat_last;

  assign accept      = (state == FILL) & bus.i_pix_valid;
  assign is_last_pix = (row == POS_MAX) & (col == POS_MAX);
  assign beat        = (state == EMIT) & bus.i_cim_ready;
  assign beat_last   = (count == CNT_MAX) & (addr == ADDR_MAX);

`ifdef CONV_IBUF_STRIDE2_EN
  // Offset from the first valid position is even iff parity matches K-1.
  localparam logic K_PAR = 1'((KERNEL_DIM - 1) % 2);
  assign in_window = (row >= K_EDGE) & (col >= K_EDGE) &
                     (row[0] == K_PAR) & (col[0] == K_PAR);
`else
  assign in_window = (row >= K_EDGE) & (col >= K_EDGE);
`endif

  assign bus.o_count     = count;
  assign bus.o_ibuf_addr = addr;
  assign bus.o_win_last  = (state == EMIT) & beat_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.o_pix_ready    = 1'b0;
    bus.o_write_enable = '0;
    bus.o_cim_valid    = 1'b0;
    bus.o_img_done     = 1'b0;
    case (state)
      FILL: begin
        bus.o_pix_ready    = 1'b1;
        bus.o_write_enable = {INPUT_CHANNELS{bus.i_pix_valid}};
        // The last pixel ends the image even when it is not a window position.
        if (accept) begin
          if (in_window) begin
            state_nxt = EMIT;
          end else if (is_last_pix) begin
            state_nxt = DONE;
          end
        end
      end
      EMIT: begin
        bus.o_cim_valid = 1'b1;
        if (beat && beat_last) begin
          state_nxt = last_pix ? DONE : FILL;
        end
      end
      DONE: begin
        bus.o_img_done = 1'b1;
        state_nxt      = FILL;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Raster position of the next pixel to be written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      last_pix <= 1'b0;
    end else if (state == DONE) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      last_pix <= is_last_pix;
      if (col == POS_MAX) begin
        col <= '0;
        row <= (row == POS_MAX) ? '0 : row + POS_W'(1);
      end else begin
        col <= col + POS_W'(1);
      end
    end
  end

  // Bit-plane outer loop, read address inner loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      addr  <= '0;
    end else if (beat) begin
      if (addr == ADDR_MAX) begin
        addr  <= '0;
        count <= (count == CNT_MAX) ? '0 : count + COUNT_WIDTH'(1);
      end else begin
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_ibuf_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_conv_ibuf_ctrl : directed bench for conv_ibuf_ctrl            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_conv_ibuf_ctrl;

  localparam int DATA_SIZE      = 8;
  localparam int IMG_DIM        = 28;
  localparam int KERNEL_DIM     = 3;
  localparam int INPUT_CHANNELS = 2;
  localparam int NUM_ADDR       = 2;
  localparam int COUNT_WIDTH    = 3;
  localparam int ADDR_WIDTH     = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_ibuf_ctrl_if #(
    .INPUT_CHANNELS(INPUT_CHANNELS),
    .COUNT_WIDTH   (COUNT_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) bus ();

  conv_ibuf_ctrl #(
    .DATA_SIZE     (DATA_SIZE),
    .IMG_DIM       (IMG_DIM),
    .KERNEL_DIM    (KERNEL_DIM),
    .INPUT_CHANNELS(INPUT_CHANNELS),
    .NUM_ADDR      (NUM_ADDR),
    .COUNT_WIDTH   (COUNT_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int n_acc, n_win, n_beat, n_done, n_valid, n_we_bad, n_order_bad;
  int exp_c, exp_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds npix pixels and drains until the block is back in FILL, tallying activity.
  task automatic stream(input int npix, input bit rnd, input int budget);
    int cyc = 0;
    n_acc = 0; n_win = 0; n_beat = 0; n_done = 0; n_valid = 0;
    n_we_bad = 0; n_order_bad = 0; exp_c = 0; exp_a = 0;
    forever begin
      if (n_acc == npix && bus.o_pix_ready) break;
      if (cyc >= budget) begin
        check("stream_timeout_acc", n_acc, npix);
        check("stream_timeout_idle", {31'b0, bus.o_pix_ready}, 1);
        break;
      end
      bus.i_cim_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_pix_valid = (n_acc < npix);
      #1;
      if (bus.o_cim_valid) begin
        n_valid++;
        if (bus.o_count !== COUNT_WIDTH'(exp_c) || bus.o_ibuf_addr !== ADDR_WIDTH'(exp_a) ||
            bus.o_win_last !== (exp_c == DATA_SIZE-1 && exp_a == NUM_ADDR-1))
          n_order_bad++;
        if (bus.o_write_enable !== '0) n_we_bad++;
        if (bus.i_cim_ready) begin
          n_beat++;
          if (bus.o_win_last) n_win++;
          if (exp_a == NUM_ADDR-1) begin
            exp_a = 0;
            exp_c = (exp_c == DATA_SIZE-1) ? 0 : exp_c + 1;
          end else begin
            exp_a++;
          end
        end
      end
      if (bus.o_img_done) n_done++;
      if (bus.i_pix_valid && bus.o_pix_ready) begin
        n_acc++;
        if (bus.o_write_enable !== '1) n_we_bad++;
      end
      cyc++;
      tick();
    end
    bus.i_pix_valid = 1'b0;
  endtask

  // Writes one pixel and measures how long input stays blocked afterwards.
  task automatic feed_one(input string tag, input bit exp_win);
    int low = 0;
    bus.i_cim_ready = 1'b1;
    bus.i_pix_valid = 1'b1;
    #1;
    check({tag, "_ready"}, {31'b0, bus.o_pix_ready}, 1);
    tick();
    bus.i_pix_valid = 1'b0;
    #1;
    check({tag, "_valid"}, {31'b0, bus.o_cim_valid}, {31'b0, exp_win});
    while (!bus.o_pix_ready && low < 40) begin
      low++;
      tick();
    end
    check({tag, "_stall"}, low, exp_win ? 16 : 0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_pix_valid = 1'b0;
    bus.i_cim_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", {31'b0, bus.o_pix_ready}, 1);
    check("rst_cim_valid", {31'b0, bus.o_cim_valid}, 0);
    check("rst_count", {29'b0, bus.o_count}, 0);
    check("rst_addr", {31'b0, bus.o_ibuf_addr}, 0);
    check("rst_win_last", {31'b0, bus.o_win_last}, 0);
    check("rst_img_done", {31'b0, bus.o_img_done}, 0);
    rst = 1'b0;
    tick();

`ifdef CONV_IBUF_STRIDE2_EN
    stream(58, 1'b0, 200);
    check("t6_pre_wins", n_win, 0);
    feed_one("t6_r2c2", 1'b1);
    feed_one("t6_r2c3", 1'b0);
    feed_one("t6_r2c4", 1'b1);
    stream(723, 1'b0, 6000);
    check("t6_wins", n_win, 167);
    check("t6_beats", n_beat, 2672);
    check("t6_done", n_done, 1);
    check("t6_order", n_order_bad, 0);
`else
    // T2: first 58 pixels produce nothing, the 59th opens the first window
    stream(58, 1'b0, 200);
    check("t2_pre_acc", n_acc, 58);
    check("t2_pre_valid", n_valid, 0);
    check("t2_pre_we", n_we_bad, 0);
    bus.i_pix_valid = 1'b1;
    bus.i_cim_ready = 1'b1;
    #1;
    check("t2_we_fill", {30'b0, bus.o_write_enable}, 3);
    tick();
    for (int i = 0; i < 16; i++) begin
      check("t2_beat_valid", {31'b0, bus.o_cim_valid}, 1);
      check("t2_beat_count", {29'b0, bus.o_count}, i / 2);
      check("t2_beat_addr", {31'b0, bus.o_ibuf_addr}, i % 2);
      check("t2_beat_last", {31'b0, bus.o_win_last}, (i == 15) ? 1 : 0);
      check("t2_beat_we", {30'b0, bus.o_write_enable}, 0);
      if (i == 15) bus.i_pix_valid = 1'b0;
      tick();
    end
    check("t2_post_ready", {31'b0, bus.o_pix_ready}, 1);
    check("t2_post_valid", {31'b0, bus.o_cim_valid}, 0);

    stream(25, 1'b0, 1000);
    check("t2_row2_wins", n_win, 25);
    check("t2_row2_order", n_order_bad, 0);

    // T3: line wrap
    feed_one("t3_r3c0", 1'b0);
    feed_one("t3_r3c1", 1'b0);
    feed_one("t3_r3c2", 1'b1);

    // T4: random backpressure across (3,3)..(4,4)
    stream(30, 1'b1, 3000);
    check("t4_wins", n_win, 28);
    check("t4_beats", n_beat, 448);
    check("t4_order", n_order_bad, 0);
    check("t4_we", n_we_bad, 0);

    // T1: asynchronous reset in the middle of a stalled window
    bus.i_cim_ready = 1'b0;
    bus.i_pix_valid = 1'b1;
    tick();
    repeat (3) tick();
    check("t1_hold_valid", {31'b0, bus.o_cim_valid}, 1);
    check("t1_hold_count", {29'b0, bus.o_count}, 0);
    check("t1_hold_we", {30'b0, bus.o_write_enable}, 0);
    bus.i_cim_ready = 1'b1;
    repeat (3) tick();
    bus.i_cim_ready = 1'b0;
    #1;
    check("t1_mid_count", {29'b0, bus.o_count}, 1);
    check("t1_mid_addr", {31'b0, bus.o_ibuf_addr}, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t1_cim_valid", {31'b0, bus.o_cim_valid}, 0);
    check("t1_pix_ready", {31'b0, bus.o_pix_ready}, 1);
    check("t1_count", {29'b0, bus.o_count}, 0);
    check("t1_addr", {31'b0, bus.o_ibuf_addr}, 0);
    bus.i_pix_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // T5: two back-to-back full images
    for (int img = 0; img < 2; img++) begin
      stream(784, 1'b0, 12500);
      check("t5_wins", n_win, 676);
      check("t5_beats", n_beat, 10816);
      check("t5_done", n_done, 1);
      check("t5_order", n_order_bad, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
